fir_coef_load_ctrl: RTL
=======================

// Module: fir_coef_load_ctrl
// PURPOSE
//  Sequencer for the 57-tap low-pass FIR in the wave-generator datapath.
//  Loads a new coefficient set through a valid/ready stream into the FIR coefficient write port.
//  Then flushes the FIR pipeline with zeros and gates the sample path into the FIR.
//  Flags when the FIR output is valid (pipeline fully refilled with post-load samples).
// PARAMETERS
//  NTAPS       57  number of coefficients per load (write addresses 0..NTAPS-1)
//  COEF_W      16  coefficient width, signed Q2.14
//  DATA_W      16  sample width, signed
//  ADDR_W      6   coefficient address width, >= clog2(NTAPS)
//  FILL_CYCLES 58  FIR input-to-output latency of the oldest tap (x -> dout via c56)
// PORTS
//  clock_50      in   1       system clock, all logic on rising edge
//  reset_n       in   1       asynchronous active-low reset
//  cfg_start     in   1       1-cycle pulse: begin coefficient load
//  run_en        in   1       level: enable filtering with current coefficients
//  coef_valid    in   1       coefficient stream beat valid
//  coef_data     in   COEF_W  coefficient value, tap 0 first
//  coef_ready    out  1       controller accepts beat (high only in LOAD)
//  coef_wr_en    out  1       FIR coefficient write strobe
//  coef_wr_addr  out  ADDR_W  FIR coefficient index
//  coef_wr_data  out  COEF_W  FIR coefficient value
//  s_data        in   DATA_W  raw sample from wave generator, one per clock
//  fir_x         out  DATA_W  registered FIR input x
//  dout_valid    out  1       FIR dout carries a fully post-load result
//  busy          out  1       high in LOAD or FLUSH
//  load_done     out  1       1-cycle pulse on the last accepted coefficient
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (fir_x=0, coef_ready=0, coef_wr_*=0, dout_valid=0).
//  States: IDLE, LOAD, FLUSH, RUN.
//  - IDLE: fir_x=0.
//    - cfg_start -> LOAD.
//    - else run_en -> FLUSH.
//    - cfg_start and run_en together: cfg_start wins.
//  - LOAD: coef_ready=1, fir_x=0.
//    - Beat accepted when coef_valid & coef_ready.
//    - Next cycle: coef_wr_en=1, coef_wr_addr=idx, coef_wr_data=coef_data; idx increments.
//    - No beat accepted -> no write; idx holds. Bubbles of any length are allowed.
//    - On the beat with idx==NTAPS-1: load_done=1 in the same cycle, coef_ready drops next cycle, -> FLUSH.
//    - cfg_start and run_en are ignored in LOAD. A load is never abandoned, and indices never wrap.
//  - FLUSH: fir_x=0 for exactly FILL_CYCLES cycles (counter 0..FILL_CYCLES-1).
//    - Then -> RUN if run_en=1, else -> IDLE.
//  - RUN: fir_x <= s_data every cycle (1-cycle register latency).
//    - Fill counter starts at 0 on RUN entry and saturates at FILL_CYCLES.
//    - dout_valid=1 from the cycle the counter reaches FILL_CYCLES.
//    - run_en=0 -> IDLE; dout_valid=0 and fir_x=0 from the next cycle.
//    - cfg_start -> LOAD; dout_valid=0 from the next cycle.
//  dout_valid is only ever 1 in RUN. busy = (state==LOAD)|(state==FLUSH).
//  No arithmetic on samples or coefficients: pass-through only, no sign change or truncation.
//  Async reset mid-LOAD/FLUSH: immediate return to IDLE. Coefficients already written stay in the FIR,
//  and the next load restarts at address 0.
// TESTING
//  1 Reset, run_en=1, cfg_start=0 -> FLUSH for 58 cycles with fir_x=0.
//    Then RUN; dout_valid rises 58 cycles after RUN entry.
//  2 cfg_start, then 57 back-to-back beats with coef_data=k+100 ->
//    - 57 writes, addr 0..56, data 100..156
//    - load_done on beat 56; busy high LOAD+FLUSH
//  3 LOAD with coef_valid toggling every other cycle -> exactly 57 writes, no duplicated or skipped address.
//  4 In RUN with dout_valid=1, pulse cfg_start ->
//    - dout_valid=0 next cycle, fir_x=0
//    - full reload and flush before dout_valid returns
//  5 reset_n low after 30 beats, then cfg_start -> first write is addr 0; outputs were 0 during reset.
//  6 IDLE with cfg_start and run_en in the same cycle -> LOAD entered, coef_ready=1 next cycle.

Source files
------------

// File: rtl/fir_coef_load_ctrl_if.sv
// Coefficient bus between the coefficient source, the load controller and the
// FIR coefficient write port. The master is the coefficient source and FIR side.
// The slave is the load controller.
interface fir_coef_load_ctrl_if #(
  parameter int COEF_W = 16,
  parameter int ADDR_W = 6
);
  logic              coef_valid;
  logic [COEF_W-1:0] coef_data;
  logic              coef_ready;
  logic              coef_wr_en;
  logic [ADDR_W-1:0] coef_wr_addr;
  logic [COEF_W-1:0] coef_wr_data;

  modport master (
    output coef_valid, coef_data,
    input  coef_ready, coef_wr_en, coef_wr_addr, coef_wr_data
  );

  modport slave (
    input  coef_valid, coef_data,
    output coef_ready, coef_wr_en, coef_wr_addr, coef_wr_data
  );
endinterface

// File: rtl/fir_coef_load_ctrl.sv
// Sequencer for the 57-tap FIR. It loads a coefficient set from a valid/ready
// stream into the FIR write port. It then flushes the FIR pipeline with zeros
// and gates raw samples into the FIR. It flags dout_valid once every tap holds
// a post-load sample.
module fir_coef_load_ctrl #(
  parameter int NTAPS       = 57,
  parameter int COEF_W      = 16,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 6,
  parameter int FILL_CYCLES = 58
) (
  input  logic              clock_50,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic              run_en,
  input  logic [DATA_W-1:0] s_data,
  output logic [DATA_W-1:0] fir_x,
  output logic              dout_valid,
  output logic              busy,
  output logic              load_done,
  fir_coef_load_ctrl_if.slave coef_bus
);

  localparam int                CNT_W     = $clog2(FILL_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NTAPS - 1);
  localparam logic [CNT_W-1:0]  FILL_LAST = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FILL_FULL = CNT_W'(FILL_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  fill_cnt;
  logic              beat;
  logic              last_beat;

  // A beat is accepted only while loading, because coef_ready is high only in LOAD.
  assign beat      = coef_bus.coef_valid && (state == LOAD);
  assign last_beat = beat && (idx == LAST_IDX);

  // State register.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic. cfg_start has priority over run_en, and a load always runs to completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cfg_start)   state_next = LOAD;
        else if (run_en) state_next = FLUSH;
      end
      LOAD: begin
        if (last_beat) state_next = FLUSH;
      end
      FLUSH: begin
        if (fill_cnt == FILL_LAST) state_next = run_en ? RUN : IDLE;
      end
      RUN: begin
        if (cfg_start)    state_next = LOAD;
        else if (!run_en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    coef_bus.coef_ready = (state == LOAD);
    busy                = (state == LOAD) || (state == FLUSH);
    load_done           = last_beat;
    dout_valid          = (state == RUN) && (fill_cnt == FILL_FULL);
  end

  // Write index. It restarts at 0 on every load and advances only on accepted beats.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n)           idx <= '0;
    else if (state != LOAD) idx <= '0;
    else if (beat)          idx <= idx + ADDR_W'(1);
  end

  // Shared flush/fill counter. It clears on every state change and saturates at FILL_CYCLES in RUN.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n)
      fill_cnt <= '0;
    else if (state_next != state)
      fill_cnt <= '0;
    else if ((state == FLUSH) || ((state == RUN) && (fill_cnt != FILL_FULL)))
      fill_cnt <= fill_cnt + CNT_W'(1);
  end

  // Registered coefficient write port. It is written one cycle after each accepted beat.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      coef_bus.coef_wr_en   <= 1'b0;
      coef_bus.coef_wr_addr <= '0;
      coef_bus.coef_wr_data <= '0;
    end else begin
      coef_bus.coef_wr_en <= beat;
      if (beat) begin
        coef_bus.coef_wr_addr <= idx;
        coef_bus.coef_wr_data <= coef_bus.coef_data;
      end
    end
  end

  // Sample gate. Samples pass only while staying in RUN, so fir_x is zero the cycle after RUN is left.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n)                                   fir_x <= '0;
    else if ((state == RUN) && (state_next == RUN)) fir_x <= s_data;
    else                                            fir_x <= '0;
  end

endmodule
